// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button debouncer with press/release/long-press pulses.
// A single shared tick counter paces sampling for every channel. Each channel
// synchronises its pin, normalises polarity, and changes its debounced level
// only after STABLE_SAMPLES consecutive equal tick samples.
module btn_debounce_multi #(
    parameter int unsigned       N_CH           = 4,
    parameter int unsigned       TICK_DIV       = 1000000,
    parameter int unsigned       STABLE_SAMPLES = 2,
    parameter int unsigned       LONG_TICKS     = 100,
    parameter logic [N_CH-1:0]   ACTIVE_LOW     = '0
) (
    input  logic            clock,
    input  logic            n_reset,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_long,
    output logic            tick_out
);

    localparam int unsigned CNT_W  = $clog2(TICK_DIV);
    localparam int unsigned HOLD_W = $clog2(LONG_TICKS + 1);
    localparam int unsigned HIST_W = STABLE_SAMPLES;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);

    logic [CNT_W-1:0]  cnt;
    logic              tick_c;
    logic [N_CH-1:0]   sync_q1;
    logic [N_CH-1:0]   sync_q2;
    logic [N_CH-1:0]   pressed_c;
    logic [HIST_W-1:0] hist        [N_CH];
    logic [HIST_W-1:0] hist_next_c [N_CH];
    logic [N_CH-1:0]   all_one_c;
    logic [N_CH-1:0]   all_zero_c;
    logic [HOLD_W-1:0] hold        [N_CH];

    assign tick_c    = (cnt == CNT_LAST);
    assign pressed_c = sync_q2 ^ ACTIVE_LOW;

    // Shared sample-tick counter and its registered observation strobe.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            cnt      <= '0;
            tick_out <= 1'b0;
        end else begin
            tick_out <= tick_c;
            cnt      <= tick_c ? '0 : cnt + CNT_W'(1);
        end
    end

    // Two-flop synchroniser for the asynchronous button pins.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= btn_in;
            sync_q2 <= sync_q1;
        end
    end

    // Sample history as it will look after this tick, and its stability flags.
    always_comb begin
        for (int i = 0; i < int'(N_CH); i++) begin
            hist_next_c[i] = HIST_W'({hist[i], pressed_c[i]});
            all_one_c[i]   = &hist_next_c[i];
            all_zero_c[i]  = ~|hist_next_c[i];
        end
    end

    // Per-channel sample shift register, loaded once per tick.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                hist[i] <= '0;
            end
        end else if (tick_c) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                hist[i] <= hist_next_c[i];
            end
        end
    end

    // Debounced level with one-cycle press/release pulses on each change.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            btn_press   <= '0;
            btn_release <= '0;
            if (tick_c) begin
                for (int i = 0; i < int'(N_CH); i++) begin
                    if (all_one_c[i] && !btn_level[i]) begin
                        btn_level[i] <= 1'b1;
                        btn_press[i] <= 1'b1;
                    end else if (all_zero_c[i] && btn_level[i]) begin
                        btn_level[i]   <= 1'b0;
                        btn_release[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Hold-time counter; saturates so each press yields a single long pulse.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                hold[i] <= '0;
            end
            btn_long <= '0;
        end else begin
            btn_long <= '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                if (!btn_level[i]) begin
                    hold[i] <= '0;
                end else if (tick_c && (hold[i] < HOLD_MAX)) begin
                    hold[i] <= hold[i] + HOLD_W'(1);
                    if (hold[i] == HOLD_LAST) begin
                        btn_long[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
